// File: rtl/fmadd_addend_aligner.sv
// FMADD front end: widens multiplicands A/B and right-aligns addend C against the
// product exponent (with sticky), two valid/ready pipeline stages.
module fmadd_addend_aligner #(
    parameter int STD = 15,
    parameter int MAN = 6,
    parameter int EXP = 7
) (
    input  logic                          clk,
    input  logic                          rst_l,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [STD+1:0]                in_a,
    input  logic [STD+1:0]                in_b,
    input  logic [STD+1:0]                in_c,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [3+EXP+2*(MAN+2)-1:0]    out_ext_a,
    output logic [3+EXP+2*(MAN+2)-1:0]    out_ext_b,
    output logic [2*(MAN+2)-1:0]          out_c_mant,
    output logic                          out_sticky,
    output logic signed [EXP+2:0]         out_exp,
    output logic                          out_c_dom,
    output logic                          out_eff_sub
);
    localparam int OPW    = STD + 2;
    localparam int MW     = MAN + 2;
    localparam int EW     = EXP + 1;
    localparam int W_M    = 2 * MW;
    localparam int W_E    = EXP + 3;
    localparam int STAGES = 2;
    localparam logic [W_E-1:0]        BIAS_U = W_E'(2 ** EXP - 1);
    localparam logic signed [W_E-1:0] WM_S   = W_E'(W_M);

    typedef struct packed {
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
        logic [OPW-1:0] c;
        logic [W_E-1:0] pe;
        logic [W_E-1:0] diff;
        logic           c_zero;
    } s1_t;

    typedef struct packed {
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
        logic [W_M-1:0] c_mant;
        logic           sticky;
        logic [W_E-1:0] exp;
        logic           c_dom;
        logic           eff_sub;
    } s2_t;

    logic [STAGES:1]        vld_pipe;
    s1_t                    s1_d, s1_q;
    s2_t                    s2_d, s2_q;
    logic                   s1_adv, s2_adv, in_fire;
    logic [W_M-1:0]         m_full;
    logic signed [W_E-1:0]  diff_s;
    logic [W_E-1:0]         ec_ext;

    assign s2_adv   = !vld_pipe[2] || out_ready;
    assign s1_adv   = s2_adv || !vld_pipe[1];
    assign in_ready = s1_adv && !flush && rst_l;
    assign in_fire  = in_valid && in_ready;

    // Product exponent and its distance to the addend exponent, kept in W_E-bit two's complement.
    always_comb begin
        s1_d.a      = in_a;
        s1_d.b      = in_b;
        s1_d.c      = in_c;
        s1_d.pe     = {2'b00, in_a[OPW-2 -: EW]} + {2'b00, in_b[OPW-2 -: EW]} - BIAS_U;
        s1_d.diff   = s1_d.pe - {2'b00, in_c[OPW-2 -: EW]};
        s1_d.c_zero = (in_c[OPW-2 -: EW] == '0) && (in_c[MW-1:0] == '0);
    end

    assign m_full = {s1_q.c[MW-1:0], {MW{1'b0}}};
    assign diff_s = s1_q.diff;
    assign ec_ext = {2'b00, s1_q.c[OPW-2 -: EW]};

    always_comb begin
        s2_d         = '0;
        s2_d.a       = s1_q.a;
        s2_d.b       = s1_q.b;
        s2_d.eff_sub = s1_q.a[OPW-1] ^ s1_q.b[OPW-1] ^ s1_q.c[OPW-1];
        s2_d.exp     = s1_q.pe;
        if (s1_q.c_zero) begin
            s2_d.c_mant = '0;
        end else if (diff_s[W_E-1] || diff_s == '0) begin
            // Addend at or above the product: left unshifted, product gets aligned downstream.
            s2_d.c_mant = m_full;
            s2_d.c_dom  = diff_s[W_E-1];
            if (diff_s[W_E-1])
                s2_d.exp = ec_ext;
        end else if (diff_s < WM_S) begin
            s2_d.c_mant = m_full >> s1_q.diff;
            s2_d.sticky = |(m_full & ~({W_M{1'b1}} << s1_q.diff));
        end else begin
            s2_d.sticky = |s1_q.c[MW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            if (flush) begin
                vld_pipe <= '0;
            end else begin
                if (s1_adv) vld_pipe[1] <= in_valid;
                if (s2_adv) vld_pipe[2] <= vld_pipe[1];
            end
            if (in_fire)
                s1_q <= s1_d;
            if (s2_adv && vld_pipe[1] && !flush)
                s2_q <= s2_d;
        end
    end

    assign out_valid   = vld_pipe[2];
    assign out_ext_a   = {s2_q.a[OPW-1], 1'b0, s2_q.a[STD:0], {MW{1'b0}}};
    assign out_ext_b   = {s2_q.b[OPW-1], 1'b0, s2_q.b[STD:0], {MW{1'b0}}};
    assign out_c_mant  = s2_q.c_mant;
    assign out_sticky  = s2_q.sticky;
    assign out_exp     = s2_q.exp;
    assign out_c_dom   = s2_q.c_dom;
    assign out_eff_sub = s2_q.eff_sub;
endmodule
